// File: rtl/layer_desc_dispatcher.sv
// Walks a table of 7-word layer descriptors in SRAM, issuing one layer at a time to the
// layer decoder and waiting for the datapath to finish each one before fetching the next.
module layer_desc_dispatcher #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] desc_base_i,
    input  logic [5:0]        num_layers_i,
    output logic              desc_rd_en_o,
    output logic [ADDR_W-1:0] desc_addr_o,
    input  logic [31:0]       desc_rdata_i,
    input  logic              layer_done_i,
    output logic              uLD_en_o,
    output logic [5:0]        layer_id_o,
    output logic [1:0]        layer_type_o,
    output logic [7:0]        in_R_o,
    output logic [7:0]        in_C_o,
    output logic [10:0]       in_D_o,
    output logic [10:0]       out_K_o,
    output logic [1:0]        stride_o,
    output logic [1:0]        pad_T_o,
    output logic [1:0]        pad_B_o,
    output logic [1:0]        pad_L_o,
    output logic [1:0]        pad_R_o,
    output logic [3:0]        flags_o,
    output logic [7:0]        quant_scale_o,
    output logic [31:0]       base_ifmap_o,
    output logic [31:0]       base_weight_o,
    output logic [31:0]       base_bias_o,
    output logic [31:0]       base_ofmap_o,
    output logic [5:0]        cur_layer_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [5:0]  layer_id;
        logic [1:0]  layer_type;
        logic [7:0]  in_r;
        logic [7:0]  in_c;
        logic [10:0] in_d;
        logic [10:0] out_k;
        logic [1:0]  stride;
        logic [1:0]  pad_t;
        logic [1:0]  pad_b;
        logic [1:0]  pad_l;
        logic [1:0]  pad_r;
        logic [3:0]  flags;
        logic [7:0]  quant_scale;
        logic [31:0] base_ifmap;
        logic [31:0] base_weight;
        logic [31:0] base_bias;
        logic [31:0] base_ofmap;
    } desc_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] desc_ptr;
    logic [5:0]        num;
    logic [5:0]        idx;
    logic [3:0]        wcnt;
    logic [2:0]        cap_idx;
    logic              cap_en;
    logic              fetch_last;
    logic              last_layer;
    desc_t             shadow;
    desc_t             fields;

    // wcnt 0..6 issue reads, 1..7 capture the word read the cycle before, 8 hands off to ISSUE
    assign fetch_last = (state == S_FETCH) && (wcnt == 4'd8);
    assign cap_en     = (state == S_FETCH) && (wcnt != 4'd0) && (wcnt <= 4'd7);
    assign cap_idx    = 3'(wcnt - 4'd1);
    assign last_layer = (({1'b0, idx} + 7'd1) == {1'b0, num});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_i) state_nxt = (num_layers_i == 6'd0) ? S_FIN : S_FETCH;
            S_FETCH:     if (fetch_last) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (layer_done_i) state_nxt = last_layer ? S_FIN : S_FETCH;
            S_FIN:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_ptr <= '0;
            num      <= '0;
            idx      <= '0;
            wcnt     <= '0;
            shadow   <= '0;
            fields   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    desc_ptr <= desc_base_i;
                    num      <= num_layers_i;
                    idx      <= '0;
                    wcnt     <= '0;
                end
                S_FETCH: begin
                    wcnt <= wcnt + 4'd1;
                    if (fetch_last) fields <= shadow;
                end
                S_WAIT_DONE: if (layer_done_i && !last_layer) begin
                    idx      <= idx + 6'd1;
                    desc_ptr <= desc_ptr + ADDR_W'(3'd7);
                    wcnt     <= '0;
                end
                default: ;
            endcase

            // Only the architected fields are kept; reserved bits are dropped on capture
            if (cap_en) begin
                case (cap_idx)
                    3'd0: begin
                        shadow.layer_id   <= desc_rdata_i[5:0];
                        shadow.layer_type <= desc_rdata_i[7:6];
                        shadow.in_r       <= desc_rdata_i[15:8];
                        shadow.in_c       <= desc_rdata_i[23:16];
                        shadow.pad_t      <= desc_rdata_i[25:24];
                        shadow.pad_b      <= desc_rdata_i[27:26];
                        shadow.pad_l      <= desc_rdata_i[29:28];
                        shadow.pad_r      <= desc_rdata_i[31:30];
                    end
                    3'd1: begin
                        shadow.in_d   <= desc_rdata_i[10:0];
                        shadow.out_k  <= desc_rdata_i[21:11];
                        shadow.stride <= desc_rdata_i[23:22];
                        shadow.flags  <= desc_rdata_i[27:24];
                    end
                    3'd2:    shadow.quant_scale <= desc_rdata_i[7:0];
                    3'd3:    shadow.base_ifmap  <= desc_rdata_i;
                    3'd4:    shadow.base_weight <= desc_rdata_i;
                    3'd5:    shadow.base_bias   <= desc_rdata_i;
                    default: shadow.base_ofmap  <= desc_rdata_i;
                endcase
            end
        end
    end

    assign desc_rd_en_o = (state == S_FETCH) && (wcnt < 4'd7);
    assign desc_addr_o  = desc_rd_en_o ? (desc_ptr + ADDR_W'(wcnt)) : '0;
    assign uLD_en_o     = (state == S_ISSUE);
    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_FIN);
    assign cur_layer_o  = idx;

    assign layer_id_o    = fields.layer_id;
    assign layer_type_o  = fields.layer_type;
    assign in_R_o        = fields.in_r;
    assign in_C_o        = fields.in_c;
    assign in_D_o        = fields.in_d;
    assign out_K_o       = fields.out_k;
    assign stride_o      = fields.stride;
    assign pad_T_o       = fields.pad_t;
    assign pad_B_o       = fields.pad_b;
    assign pad_L_o       = fields.pad_l;
    assign pad_R_o       = fields.pad_r;
    assign flags_o       = fields.flags;
    assign quant_scale_o = fields.quant_scale;
    assign base_ifmap_o  = fields.base_ifmap;
    assign base_weight_o = fields.base_weight;
    assign base_bias_o   = fields.base_bias;
    assign base_ofmap_o  = fields.base_ofmap;

endmodule
